// File: rtl/iobuf_hdx_ctrl.sv
// Half-duplex sequencer for a bank of tri-state pad buffers: turns write/read
// handshakes into pad drive/sample activity with turnaround gaps between directions.
module iobuf_hdx_ctrl #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_valid,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_wr_ready,
    input  logic             i_rd_req,
    output logic             o_rd_ready,
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [WIDTH-1:0] o_pad_i,
    output logic             o_pad_t,
    input  logic [WIDTH-1:0] i_pad_o
);

    typedef enum logic [1:0] {
        ST_RX      = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_TX      = 2'd2,
        ST_TURN_RX = 2'd3
    } state_t;

    localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic             r_pad_t, w_pad_t_nxt;
    logic [WIDTH-1:0] r_pad_i, w_pad_i_nxt;
    logic [WIDTH-1:0] r_rd_data, w_rd_data_nxt;
    logic             r_rd_valid, w_rd_valid_nxt;
    logic             w_wr_ready, w_rd_ready;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pad_t_nxt    = r_pad_t;
        w_pad_i_nxt    = r_pad_i;
        w_rd_data_nxt  = r_rd_data;
        w_rd_valid_nxt = 1'b0;
        w_wr_ready     = 1'b0;
        w_rd_ready     = 1'b0;

        unique case (r_state)
            ST_RX: begin
                w_rd_ready  = 1'b1;
                w_pad_t_nxt = 1'b1;
                if (i_rd_req) begin
                    w_rd_data_nxt  = i_pad_o;
                    w_rd_valid_nxt = 1'b1;
                end
                if (i_wr_valid) begin
                    w_state_nxt = ST_TURN_TX;
                    w_cnt_nxt   = TURN_LOAD;
                end
            end
            ST_TURN_TX: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_wr_ready = 1'b1;
                    if (i_wr_valid) begin
                        // Enable and first word land on the same edge: no stale data is driven.
                        w_pad_i_nxt = i_wr_data;
                        w_pad_t_nxt = 1'b0;
                        w_state_nxt = ST_TX;
                    end else if (i_rd_req) begin
                        w_state_nxt = ST_RX;
                    end
                end
            end
            ST_TX: begin
                w_wr_ready = 1'b1;
                if (i_wr_valid) begin
                    w_pad_i_nxt = i_wr_data;
                end else if (i_rd_req) begin
                    w_pad_t_nxt = 1'b1;
                    w_cnt_nxt   = TURN_LOAD;
                    w_state_nxt = ST_TURN_RX;
                end
            end
            ST_TURN_RX: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_state_nxt = ST_RX;
                end
            end
            default: w_state_nxt = ST_RX;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset releases the pads at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_RX;
            r_cnt      <= 8'd0;
            r_pad_t    <= 1'b1;
            r_pad_i    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pad_t    <= w_pad_t_nxt;
            r_pad_i    <= w_pad_i_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
        end
    end

    assign o_wr_ready = w_wr_ready;
    assign o_rd_ready = w_rd_ready;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_pad_i    = r_pad_i;
    assign o_pad_t    = r_pad_t;

endmodule

// File: tb/tb_iobuf_hdx_ctrl.sv
// Bench for iobuf_hdx_ctrl: scenario tasks with inline checks plus a handshake
// scoreboard that predicts read samples and driven words from the stimulus.
module tb_iobuf_hdx_ctrl;

    localparam int WIDTH = 8;
    localparam int TURN  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_valid = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_ready;
    logic             rd_req = 1'b0;
    logic             rd_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] pad_i;
    logic             pad_t;
    logic [WIDTH-1:0] pad_o = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] rd_q[$];
    logic [WIDTH-1:0] wr_q[$];
    int               rel_cnt = 100;

    iobuf_hdx_ctrl #(.WIDTH(WIDTH), .TURN_CYCLES(TURN)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_valid (wr_valid),
        .i_wr_data  (wr_data),
        .o_wr_ready (wr_ready),
        .i_rd_req   (rd_req),
        .o_rd_ready (rd_ready),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_pad_i    (pad_i),
        .o_pad_t    (pad_t),
        .i_pad_o    (pad_o)
    );

    always #5 clk = ~clk;

    // Handshakes are decided mid-cycle, where inputs and ready are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_q.delete();
            wr_q.delete();
            rel_cnt = 100;
        end else begin
            if (rd_req && rd_ready) begin
                rd_q.push_back(pad_o);
                n_checks++;
                if (pad_t !== 1'b1 || rel_cnt < TURN) begin
                    n_fail++;
                    $display("FAIL released_before_sample: pad_t=%b released_cycles=%0d need pad_t=1 and >=%0d",
                             pad_t, rel_cnt, TURN);
                end
            end
            if (wr_valid && wr_ready) wr_q.push_back(wr_data);
            if (pad_t === 1'b0) rel_cnt = 0;
            else                rel_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (rd_q.size() != 0) begin
                logic [WIDTH-1:0] exp_rd;
                exp_rd = rd_q.pop_front();
                n_checks++;
                if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
                    n_fail++;
                    $display("FAIL sb_read: rd_valid=%b rd_data=%h expected 1/%h", rd_valid, rd_data, exp_rd);
                end
            end else if (rd_valid !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_rd_valid: rd_valid=%b expected 0", rd_valid);
            end
            if (wr_q.size() != 0) begin
                logic [WIDTH-1:0] exp_wr;
                exp_wr = wr_q.pop_front();
                n_checks++;
                if (pad_t !== 1'b0 || pad_i !== exp_wr) begin
                    n_fail++;
                    $display("FAIL sb_write: pad_t=%b pad_i=%h expected 0/%h", pad_t, pad_i, exp_wr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (pad_t !== 1'b1 || pad_i !== '0 || rd_data !== '0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: pad_t=%b pad_i=%h rd_data=%h rd_valid=%b expected 1/00/00/0",
                     pad_t, pad_i, rd_data, rd_valid);
        end
        n_checks++;
        if (rd_ready !== 1'b1 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: rd_ready=%b wr_ready=%b expected 1/0", rd_ready, wr_ready);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_burst();
        logic [WIDTH-1:0] samples[3] = '{8'h5A, 8'h5B, 8'h5C};
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1;
            pad_o  = samples[i];
            n_checks++;
            if (pad_t !== 1'b1 || rd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL burst_rx[%0d]: pad_t=%b rd_ready=%b expected 1/1", i, pad_t, rd_ready);
            end
            tick();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== samples[i]) begin
                n_fail++;
                $display("FAIL burst_sample[%0d]: rd_valid=%b rd_data=%h expected 1/%h",
                         i, rd_valid, rd_data, samples[i]);
            end
        end
        rd_req = 1'b0;
        pad_o  = 8'h00;
        tick();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h5C) begin
            n_fail++;
            $display("FAIL burst_hold: rd_valid=%b rd_data=%h expected 0/5c", rd_valid, rd_data);
        end
    endtask

    task automatic test_rx_to_tx(input logic [WIDTH-1:0] d);
        logic [2:0] exp_ready = 3'b100;
        wr_valid = 1'b1;
        wr_data  = d;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (wr_ready !== exp_ready[c] || pad_t !== 1'b1) begin
                n_fail++;
                $display("FAIL turn_tx_cycle%0d: wr_ready=%b pad_t=%b expected %b/1",
                         c, wr_ready, pad_t, exp_ready[c]);
            end
            tick();
        end
        wr_valid = 1'b0;
        n_checks++;
        if (pad_t !== 1'b0 || pad_i !== d) begin
            n_fail++;
            $display("FAIL first_drive: pad_t=%b pad_i=%h expected 0/%h", pad_t, pad_i, d);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            tick();
            n_checks++;
            if (pad_t !== 1'b0 || pad_i !== 8'(i)) begin
                n_fail++;
                $display("FAIL b2b_word%0d: pad_t=%b pad_i=%h expected 0/%h", i, pad_t, pad_i, 8'(i));
            end
        end
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        pad_o    = 8'h3C;
        for (int c = 1; c <= TURN; c++) begin
            tick();
            n_checks++;
            if (pad_t !== 1'b1 || rd_ready !== 1'b0 || wr_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL turn_rx_cycle%0d: pad_t=%b rd_ready=%b wr_ready=%b expected 1/0/0",
                         c, pad_t, rd_ready, wr_ready);
            end
        end
        tick();
        n_checks++;
        if (rd_ready !== 1'b1 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_entry: rd_ready=%b rd_valid=%b expected 1/0", rd_ready, rd_valid);
        end
        tick();
        rd_req = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL tx_to_read: rd_valid=%b rd_data=%h expected 1/3c", rd_valid, rd_data);
        end
    endtask

    task automatic test_write_wins();
        test_rx_to_tx(8'h90);
        rd_req   = 1'b1;
        pad_o    = 8'hC3;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h11 * 8'(i + 1);
            tick();
            n_checks++;
            if (pad_t !== 1'b0 || pad_i !== 8'h11 * 8'(i + 1) || wr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL write_wins%0d: pad_t=%b pad_i=%h wr_ready=%b expected 0/%h/1",
                         i, pad_t, pad_i, wr_ready, 8'h11 * 8'(i + 1));
            end
        end
        wr_valid = 1'b0;
        tick();
        n_checks++;
        if (pad_t !== 1'b1 || rd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wins_turn: pad_t=%b rd_ready=%b expected 1/0", pad_t, rd_ready);
        end
        repeat (TURN) tick();
        n_checks++;
        if (rd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wins_rx: rd_ready=%b expected 1", rd_ready);
        end
        tick();
        rd_req = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL wins_read: rd_valid=%b rd_data=%h expected 1/c3", rd_valid, rd_data);
        end
        tick();
    endtask

    task automatic test_abort_turn();
        logic [3:0] exp_rd_ready = 4'b1001;
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        pad_o    = 8'h47;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (pad_t !== 1'b1 || rd_ready !== exp_rd_ready[c]) begin
                n_fail++;
                $display("FAIL abort_cycle%0d: pad_t=%b rd_ready=%b expected 1/%b",
                         c, pad_t, rd_ready, exp_rd_ready[c]);
            end
            tick();
            if (c == 0) wr_valid = 1'b0;
            if (c == 1) rd_req = 1'b1;
        end
        rd_req = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h47 || pad_t !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_read: rd_valid=%b rd_data=%h pad_t=%b expected 1/47/1",
                     rd_valid, rd_data, pad_t);
        end
        tick();
    endtask

    task automatic test_async_reset();
        test_rx_to_tx(8'h77);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (pad_t !== 1'b1 || rd_valid !== 1'b0 || pad_i !== '0) begin
            n_fail++;
            $display("FAIL async_reset: pad_t=%b rd_valid=%b pad_i=%h expected 1/0/00",
                     pad_t, rd_valid, pad_i);
        end
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        n_checks++;
        if (rd_ready !== 1'b1 || wr_ready !== 1'b0 || pad_t !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: rd_ready=%b wr_ready=%b pad_t=%b expected 1/0/1",
                     rd_ready, wr_ready, pad_t);
        end
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_rx_to_tx(8'hA5);
        test_back_to_back();
        test_write_wins();
        test_abort_turn();
        test_async_reset();
        tick();
        n_checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: rd_q=%0d wr_q=%0d expected 0/0", rd_q.size(), wr_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
